// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// ----------------------------------------------------------------------------
// 8N1 UART receiver with a small show-ahead receive FIFO.
//
// The serial line is brought into the clock domain by a 2-FF synchronizer.
// A five-state FSM (IDLE, START, DATA, STOP, WAIT_HIGH) finds the start edge,
// confirms it at mid-bit, then samples eight data bits LSB first and the stop
// bit at bit centres. Good bytes go into the FIFO. Framing errors and FIFO
// overruns are reported as single-cycle pulses.
//
// Optional build macro: UART_RX_PARITY_EN
//   When defined, a PARITY state between DATA and STOP samples a ninth bit.
//   PARITY_ODD selects the parity sense (0 = even, 1 = odd). A parity mismatch
//   discards the byte and raises frame_err_o after the stop bit.
//   When undefined, the frame is strict 8N1.
//
// Parameters:
//   CLK_FREQ    system clock frequency in Hz
//   BAUDRATE    line rate in bit/s (BAUD_DIV = CLK_FREQ / BAUDRATE)
//   FIFO_DEPTH  receive FIFO entries, power of two, >= 2
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   uart_rx_i    serial input, idles high, asynchronous to clk
//   rx_data_o    FIFO head byte, meaningful while rx_valid_o = 1
//   rx_valid_o   FIFO not empty
//   rx_ready_i   consumer pops the head when rx_valid_o & rx_ready_i
//   frame_err_o  one-cycle pulse: bad stop bit (or parity mismatch)
//   overrun_o    one-cycle pulse: completed byte dropped, FIFO full
//   busy_o       receiver FSM not idle
// ----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUDRATE   = 115200,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    input  logic       rx_ready_i,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic       busy_o
);

    localparam int unsigned BAUD_DIV = CLK_FREQ / BAUDRATE;
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned AW       = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } state_e;

    // ------------------------------------------------------------------------
    // Input synchronizer. Both stages reset to the idle-high line level, so
    // reset never looks like a start edge.
    // ------------------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= uart_rx_i;
            rxs_q     <= rx_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             frame_err_q, frame_err_d;
    logic             byte_done;
`ifdef UART_RX_PARITY_EN
    logic             par_err_q, par_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d   = par_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs_q) begin
                    state_d = StStart;
                end
            end

            // Re-check the line at mid start bit; a high level means the
            // falling edge was a glitch and is silently dropped.
            StStart: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? StIdle : StData;
                end
            end

            StData: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            // XOR over data plus parity bit is 0 for even parity, 1 for odd.
            StParity: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d     = '0;
                    par_err_d = ((^shift_q) ^ rxs_q) != PARITY_ODD;
                    state_d   = StStop;
                end
            end
`endif

            StStop: begin
                if (cnt_q == BAUD_LAST) begin
                    cnt_d = '0;
                    if (rxs_q) begin
                        state_d = StIdle;
`ifdef UART_RX_PARITY_EN
                        if (par_err_q) begin
                            frame_err_d = 1'b1;
                        end else begin
                            byte_done = 1'b1;
                        end
`else
                        byte_done = 1'b1;
`endif
                    end else begin
                        // Low stop bit: wait for the line to recover so a
                        // break reports a single error, not a stream of them.
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end
                end
            end

            StWaitHigh: begin
                cnt_d = '0;
                if (rxs_q) begin
                    state_d = StIdle;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end
`endif

    // ------------------------------------------------------------------------
    // Receive FIFO. Pointers carry an extra wrap bit to tell full from empty.
    // ------------------------------------------------------------------------
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        fifo_empty;
    logic        fifo_full;
    logic        do_pop;
    logic        do_push;
    logic        overrun_q, overrun_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a full FIFO needs for the write.
    assign do_pop    = !fifo_empty && rx_ready_i;
    assign do_push   = byte_done && (!fifo_full || do_pop);
    assign overrun_d = byte_done && fifo_full && !do_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            overrun_q <= overrun_d;
        end
    end

    // Storage needs no reset; the read side is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign rx_valid_o  = !fifo_empty;
    assign rx_data_o   = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed serial frames with a queue-based
// reference model checked every clock, plus literal spot checks.
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ = 1600000;
    localparam int unsigned BAUDRATE = 100000;
    localparam int unsigned DEPTH    = 4;
    localparam int BAUD = CLK_FREQ / BAUDRATE;   // 16 clocks per bit
    localparam int HALF = BAUD / 2;              // 8
    // Start edge to stop-bit sample: 2 sync stages + 1 idle detect,
    // half a bit, then nine full bits.
    localparam int LAT  = 3 + HALF + 9 * BAUD;   // 155

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUDRATE  (BAUDRATE),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx_i  (uart_rx),
        .rx_data_o  (rx_data),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .busy_o     (busy)
    );

    typedef struct {
        int         cyc;
        logic [7:0] data;
        bit         err;
    } ev_t;

    ev_t        ev_q[$];
    ev_t        cur_ev;
    logic [7:0] mq[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    int         pop_cnt = 0;
    int         ferr_seen = 0;
    int         ovr_seen = 0;
    int         last_rise = -1;
    bit         prev_valid = 1'b0;
    bit         exp_ferr;
    bit         exp_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: FIFO contents as a queue, frame outcomes as timed events.
    always begin
        @(posedge clk);
        cyc = cyc + 1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (rst) begin
            mq.delete();
            ev_q.delete();
        end else begin
            if (mq.size() != 0 && rx_ready) begin
                void'(mq.pop_front());
                pop_cnt++;
            end
            while (ev_q.size() != 0 && ev_q[0].cyc <= cyc) begin
                cur_ev = ev_q.pop_front();
                if (cur_ev.err) begin
                    exp_ferr = 1'b1;
                end else if (mq.size() < DEPTH) begin
                    mq.push_back(cur_ev.data);
                end else begin
                    exp_ovr = 1'b1;
                end
            end
        end
        #1;
        check("valid", rx_valid, mq.size() != 0);
        if (mq.size() != 0) check("data", rx_data, mq[0]);
        check("frame_err", frame_err, exp_ferr);
        check("overrun", overrun, exp_ovr);
        if (frame_err) ferr_seen++;
        if (overrun) ovr_seen++;
        if (rx_valid && !prev_valid) last_rise = cyc;
        prev_valid = rx_valid;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
    endtask

    task automatic do_reset_mid();
        rst = 1'b1;
        uart_rx = 1'b1;
        mq.delete();
        ev_q.delete();
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_ovr", overrun, 0);
        idle(3);
        rst = 1'b0;
    endtask

    // Called on a falling clock edge; abort_bit < 10 resets the DUT at the
    // start of that frame bit instead of driving it.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
        logic [9:0] bits;
        ev_t        e;
        bits   = {stop_bit, b, 1'b0};
        e.cyc  = cyc + LAT;
        e.data = b;
        e.err  = !stop_bit;
        ev_q.push_back(e);
        for (int i = 0; i < 10; i++) begin
            if (i == abort_bit) begin
                do_reset_mid();
                return;
            end
            uart_rx = bits[i];
            idle(BAUD);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int base;
        logic [7:0] b;

        idle(4);
        check("reset_valid", rx_valid, 0);
        check("reset_data", rx_data, 0);
        check("reset_busy", busy, 0);
        check("reset_ferr", frame_err, 0);
        check("reset_ovr", overrun, 0);
        rst = 1'b0;
        idle(4);

        // Single byte, consumer not ready.
        c0 = cyc;
        send_frame(8'h55, 1'b1, 99);
        check("t1_latency", last_rise - c0, 155);
        check("t1_valid", rx_valid, 1);
        check("t1_data", rx_data, 8'h55);
        idle(BAUD);
        pop_one();
        check("t1_drained", rx_valid, 0);

        // Short glitch, shorter than half a bit.
        c0 = cyc;
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(3);
        check("glitch_busy", busy, 1);
        idle(6);
        check("glitch_idle", busy, 0);
        check("glitch_valid", rx_valid, 0);
        idle(BAUD);

        // Bad stop bit followed by a break, then a clean byte.
        base = ferr_seen;
        send_frame(8'hA3, 1'b0, 99);
        uart_rx = 1'b0;
        idle(3 * BAUD);
        uart_rx = 1'b1;
        idle(2 * BAUD);
        check("break_ferr_count", ferr_seen - base, 1);
        check("break_valid", rx_valid, 0);
        send_frame(8'h3C, 1'b1, 99);
        check("after_break_valid", rx_valid, 1);
        check("after_break_data", rx_data, 8'h3C);
        pop_one();
        idle(BAUD);

        // Five bytes into a four-entry FIFO.
        base = ovr_seen;
        for (int i = 1; i <= 5; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 99);
        end
        idle(BAUD);
        check("ovr_count", ovr_seen - base, 1);
        for (int i = 1; i <= 4; i++) begin
            check("drain_valid", rx_valid, 1);
            check("drain_data", rx_data, i);
            pop_one();
        end
        check("drain_empty", rx_valid, 0);

        // Continuous stream with the consumer always ready.
        rx_ready = 1'b1;
        base = pop_cnt;
        c0 = ovr_seen;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            send_frame(b, 1'b1, 99);
        end
        idle(BAUD);
        rx_ready = 1'b0;
        check("stream_pops", pop_cnt - base, 256);
        check("stream_ovr", ovr_seen - c0, 0);
        check("stream_empty", rx_valid, 0);

        // Reset in the middle of a frame with two bytes queued.
        send_frame(8'h11, 1'b1, 99);
        send_frame(8'h22, 1'b1, 99);
        check("pre_rst_valid", rx_valid, 1);
        check("pre_rst_data", rx_data, 8'h11);
        send_frame(8'h99, 1'b1, 5);
        check("post_rst_valid", rx_valid, 0);
        idle(2 * BAUD);
        send_frame(8'h7E, 1'b1, 99);
        check("post_rst_rx_valid", rx_valid, 1);
        check("post_rst_rx_data", rx_data, 8'h7E);
        pop_one();
        check("final_empty", rx_valid, 0);
        idle(BAUD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- UART receiver for BearCore-V: deserializes an asynchronous 8N1 serial line (the host-to-core direction, complementing uart_tx_o) into bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready interface to the core's memory-mapped UART register block.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUDRATE, 115200, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUDRATE (integer truncation, 868 at defaults), HALF_DIV = BAUD_DIV/2 (434).
- FIFO_DEPTH, 4, receive FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- uart_rx_i  input  1  serial line; idles high, asynchronous to clk.
- rx_data_o  output  8  FIFO head byte; valid only while rx_valid_o=1.
- rx_valid_o  output  1  FIFO non-empty.
- rx_ready_i  input  1  consumer pops head when rx_valid_o & rx_ready_i.
- frame_err_o  output  1  one-cycle pulse: stop bit sampled low (or parity error, see Optional Feature).
- overrun_o  output  1  one-cycle pulse: completed byte dropped because FIFO full.
- busy_o  output  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (async assert, sync release): 2-FF synchronizer = 1, FSM = IDLE, counters = 0, FIFO empty; rx_data_o=0, rx_valid_o=0, frame_err_o=0, overrun_o=0, busy_o=0.
- The FSM only reads the synchronized line rxs (2 clk latency).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rxs=0 -> START, baud counter = 0.
- START: at counter = HALF_DIV-1, sample rxs.
  - 0 -> DATA, counter = 0, bit index = 0.
  - 1 -> IDLE (glitch rejected, nothing reported).
- DATA: every BAUD_DIV cycles, sample rxs into shift register, LSB first. After bit 7 is sampled -> STOP.
- STOP: at counter = BAUD_DIV-1, sample rxs.
  - 1 -> byte complete, FIFO write attempted this cycle, -> IDLE.
  - 0 -> frame_err_o pulses next cycle, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: remain until rxs=1, then -> IDLE. A break condition therefore yields exactly one frame error.
- Baud counter counts 0..BAUD_DIV-1 and wraps to 0 at each sample.
- Latency: rx_valid_o rises on the cycle after the stop-bit sample (about 9.5 bit times + 3 clk after the start edge) when the FIFO was empty.
- FIFO: registered read/write pointers with an extra wrap bit; rx_data_o is driven from mem[rd_ptr] (show-ahead).
  - Pop and write in the same cycle when full: both succeed, no overrun.
  - Pop and write in the same cycle when empty: write succeeds, the pop is ignored because valid=0.
  - Write when full with no pop: byte dropped, overrun_o pulses next cycle, FIFO contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH; ordering is strictly FIFO.
- rx_ready_i while rx_valid_o=0: no effect.
- Reset mid-frame: partial byte discarded, FIFO flushed; after release, a frame already in progress may be picked up at a later falling edge and produce a frame error.
- Error pulses are exactly one cycle wide and never overlap a FIFO write of the same frame.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- When defined: parameter PARITY_ODD (default 0 = even) and state PARITY, inserted between DATA and STOP, which samples a 9th bit.
  - A parity mismatch discards the byte and pulses frame_err_o after STOP, whatever the stop-bit value.
  - A stop bit sampled low then proceeds to WAIT_HIGH as in the base block.
- When not defined: no PARITY state, no parity logic; the frame is strict 8N1.

Test Plan:
- Defaults: drive 0x55 at 8680 ns/bit, rx_ready_i=0 -> rx_valid_o rises about 82.5 us after the start edge, rx_data_o=0x55, no error pulses.
- 200 ns low glitch on an idle line -> FSM returns to IDLE after HALF_DIV cycles; rx_valid_o, frame_err_o and overrun_o stay 0.
- Send 0xA3 with stop bit forced low, then hold the line low for 3 bit times -> exactly one frame_err_o pulse, FIFO stays empty; next valid byte 0x3C is received correctly.
- Send 0x01..0x05 back-to-back with rx_ready_i=0 -> one overrun_o pulse after byte 5; draining yields 0x01,0x02,0x03,0x04, then rx_valid_o=0.
- rx_ready_i=1 held during continuous stream 0x00..0xFF -> all 256 bytes popped in order, no overrun.
- Assert rst during DATA bit 4 of a frame with 2 bytes queued -> all outputs 0 immediately, FIFO empty; a following clean frame 0x7E is received correctly.
